// File: rtl/pwm_peripheral.sv
// 16-pin PWM driver fed by the SPI register block; one shared ~3 kHz waveform.
// Define PWM_SHADOW_DUTY_EN to load the duty only at period boundaries.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] en_out,
    input  logic [15:0] en_pwm,
    input  logic [7:0]  pwm_duty,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

    logic [15:0] prescaler;
    logic [7:0]  pwm_cnt;
    logic [7:0]  duty_active;
    logic        tick;
    logic        wrap;
    logic        level;

    assign tick  = (prescaler == DIV_MAX);
    assign wrap  = tick && (pwm_cnt == 8'hFF);
    // Full scale is special-cased so 0xFF never drops for the last step.
    assign level = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler    <= 16'd0;
            pwm_cnt      <= 8'd0;
            duty_active  <= 8'd0;
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            prescaler    <= tick ? 16'd0 : prescaler + 16'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            period_start <= wrap;
            out          <= en_out & (~en_pwm | {16{level}});
`ifdef PWM_SHADOW_DUTY_EN
            if (wrap) begin
                duty_active <= pwm_duty;
            end
`else
            duty_active  <= pwm_duty;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with CLK_DIV=13 (period 3328 clocks).
// Expected high times are D*13 clocks, hand-derived for each duty.
module tb_pwm_peripheral;

    localparam int PERIOD = 3328;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_out = 16'hFFFF;
    logic [15:0] en_pwm = 16'hFFFF;
    logic [7:0]  pwm_duty = 8'hFF;
    logic [15:0] out;
    logic        period_start;

    int checks = 0;
    int failures = 0;

    always #50 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(13)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_out      (en_out),
        .en_pwm      (en_pwm),
        .pwm_duty    (pwm_duty),
        .out         (out),
        .period_start(period_start)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Steps negedges until period_start is seen; n = negedges taken.
    task automatic wait_ps(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 4000);
        check({tag, "_ps_found"}, {31'd0, period_start}, 32'd1);
    endtask

    task automatic settle(input string tag);
        int n;
        wait_ps(tag, n);
        wait_ps(tag, n);
    endtask

    // Starts on a period_start sample, ends on the next one.
    task automatic measure(input string tag, input int exp_high,
                           input int change_at, input logic [7:0] new_duty);
        int high;
        int upper;
        int phase;
        int extra;
        high = 0;
        upper = 0;
        phase = 0;
        extra = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (period_start !== 1'b0) extra++;
            end
            if (out[0] === 1'b1) high++;
            if (out[15:8] !== 8'h00) upper++;
            if (out[7:0] !== {8{out[0]}}) phase++;
            if (i == change_at) pwm_duty = new_duty;
        end
        @(negedge clk);
        check({tag, "_high"}, high, exp_high);
        check({tag, "_upper"}, upper, 0);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_extra_ps"}, extra, 0);
        check({tag, "_next_ps"}, {31'd0, period_start}, 32'd1);
    endtask

    initial begin
        int bad;
        int n;

        // Reset held with all inputs at maximum.
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out !== 16'h0000 || period_start !== 1'b0) bad++;
        end
        check("rst_hold", bad, 0);
        rst_n = 1'b1;
        wait_ps("rst_rel", n);
        check("rst_first_ps", n, PERIOD);

        // Static enables.
        en_out = 16'h0005;
        en_pwm = 16'h0000;
        @(negedge clk);
        check("static_on", {16'd0, out}, 32'h0005);
        en_out = 16'h0000;
        @(negedge clk);
        check("static_off", {16'd0, out}, 32'h0000);
        en_pwm = 16'hFFFF;
        @(negedge clk);
        check("pwm_only", {16'd0, out}, 32'h0000);
        en_out = 16'h0005;
        en_pwm = 16'h0001;
        @(negedge clk);
        check("mix_full", {16'd0, out}, 32'h0005);

        // Duty extremes.
        en_out = 16'h00FF;
        en_pwm = 16'h00FF;
        pwm_duty = 8'h00;
        settle("d00");
        measure("d00", 0, -1, 8'h00);
        en_out = 16'hFFFF;
        en_pwm = 16'h0F00;
        @(negedge clk);
        check("mixed_f0ff", {16'd0, out}, 32'hF0FF);
        en_out = 16'h00FF;
        en_pwm = 16'h00FF;
        pwm_duty = 8'hFF;
        settle("dff");
        measure("dff", PERIOD, -1, 8'hFF);

        // 50 percent.
        pwm_duty = 8'h80;
        settle("d80");
        measure("d80", 1664, -1, 8'h80);

        // Mid-period duty change at pwm_cnt=100 (sample 1300).
        pwm_duty = 8'h40;
        settle("d40");
`ifdef PWM_SHADOW_DUTY_EN
        measure("chg_cur", 832, 1300, 8'hC0);
`else
        measure("chg_cur", 832 + (2496 - 1301), 1300, 8'hC0);
`endif
        measure("chg_next", 2496, -1, 8'hC0);

        // Reset mid-period at pwm_cnt=0x50.
        pwm_duty = 8'h80;
        settle("mid");
        repeat (13 * 8'h50) @(negedge clk);
        check("mid_high", {16'd0, out}, 32'h00FF);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out", {16'd0, out}, 32'h0000);
        check("mid_rst_ps", {31'd0, period_start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ps("mid_rel", n);
        check("mid_first_ps", n, PERIOD);
        measure("mid_after", 1664, -1, 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Drives 16 output pins from the control registers written over the SPI register interface: per-pin output enable, per-pin PWM enable, one shared 8-bit duty cycle.
- Sits directly downstream of the SPI register block; consumes its three register outputs unchanged and drives the design's output pins.
- Generates one ~3 kHz PWM waveform from the 10 MHz system clock. Each pin is forced low, forced high, or follows the PWM waveform.

Parameters:
- CLK_DIV, 13, system clocks per PWM counter step. Period = 256*CLK_DIV clocks (3328 clocks, about 3.005 kHz at 10 MHz). Legal range 1..65535.

Ports:
- clk  input  1  system clock, 10 MHz
- rst_n  input  1  synchronous active-low reset
- en_out  input  16  per-pin output enable; bit i gates out[i]
- en_pwm  input  16  per-pin PWM enable; meaningful only where en_out[i]=1
- pwm_duty  input  8  shared duty cycle; 0x00 = 0 %, 0xFF = 100 %
- out  output  16  registered pin outputs
- period_start  output  1  registered one-clock pulse on the first clock of each PWM period

Behaviour:
- Reset is synchronous to clk and active-low (rst_n). While rst_n=0 at a rising edge:
  - prescaler <= 0, pwm_cnt <= 0, duty_active <= 0
  - out <= 16'h0000, period_start <= 0
- Prescaler:
  - 16-bit counter, 0..CLK_DIV-1.
  - tick = (prescaler == CLK_DIV-1). On tick the prescaler wraps to 0.
  - With CLK_DIV=1, tick is asserted every clock.
- PWM counter:
  - 8-bit pwm_cnt increments by 1 on tick only.
  - Wraps 255 -> 0 naturally; no saturation.
- Period boundary: wrap = tick && (pwm_cnt == 255).
  - On wrap, period_start <= 1 for exactly one clock, which is the clock where pwm_cnt is first 0.
  - Otherwise period_start <= 0.
- Level, combinational: level = (duty_active == 8'hFF) || (pwm_cnt < duty_active).
  - Duty 0x00: never high.
  - Duty 0xFF: always high, with no one-step glitch.
  - Any other duty D: high for D*CLK_DIV clocks per period, starting at period start.
- Output, registered every clock. For each bit i:
  - en_out[i]=0 -> out[i] <= 0, regardless of en_pwm[i]
  - en_out[i]=1, en_pwm[i]=0 -> out[i] <= 1
  - en_out[i]=1, en_pwm[i]=1 -> out[i] <= level
- Latency:
  - en_out and en_pwm are not shadowed. A change is visible on out one clock after it is sampled.
  - duty_active update rule is governed by the optional feature below.
- All 16 PWM pins share phase and duty; no per-pin offset.
- Inputs are registers in the same clk domain; no synchronisers are required.
- Reset mid-period: counters and outputs clear at the next edge. The waveform restarts from pwm_cnt=0 after release. The first period_start after reset occurs 256*CLK_DIV clocks after release.
- Simultaneous events:
  - A duty change in the same clock as wrap is captured for the new period (shadow mode).
  - An enable change in the same clock as wrap takes effect on out at the next edge, as usual.

Optional Feature:
- Macro: PWM_SHADOW_DUTY_EN
- Defined:
  - duty_active loads pwm_duty only on wrap, i.e. at the period boundary.
  - The current period always completes with the duty it started with, so no truncated or extended pulses.
  - After reset, duty_active stays 0 until the first wrap.
- Not defined:
  - duty_active <= pwm_duty every clock, one-clock delay.
  - A mid-period change may produce one irregular pulse.
  - period_start behaviour is unchanged.

Test Plan:
1. Reset: hold rst_n=0 for 5 clocks with all inputs at their maximum -> out=0x0000 and period_start=0 throughout. After release, first period_start pulse 3328 clocks later.
2. Static enables: en_out=0x0005, en_pwm=0x0000 -> out=0x0005 one clock later. Then en_out=0x0000 -> out=0x0000 one clock later. en_pwm alone never raises a pin.
3. 50 % duty, CLK_DIV=13: en_out=en_pwm=0x00FF, pwm_duty=0x80, measured after one full period -> out[7:0] high 1664 clocks, low 1664 clocks, period 3328; out[15:8]=0.
4. Extremes: pwm_duty=0x00 -> PWM pins low for a whole period. pwm_duty=0xFF -> PWM pins high every clock of a whole period. Mixed en_pwm=0x0F00, en_out=0xFFFF, duty 0x00 -> out=0xF0FF.
5. Shadow (PWM_SHADOW_DUTY_EN defined): duty 0x40 steady, change to 0xC0 at pwm_cnt=100 -> current period high 832 clocks, next period high 2496 clocks. Without the macro, the current period's high time ends at pwm_cnt=0xC0 instead.
6. Reset mid-period: assert rst_n=0 at pwm_cnt=0x50 with PWM pins high -> out=0x0000 at next edge. After release the waveform restarts at count 0 and the period_start spacing is 3328 clocks.
